// File: rtl/prog_sequencer_pkg.sv
// Shared types and defaults for the program-load / run / register-dump sequencer.
package prog_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] IDLE_RID       = 4'hF;
    localparam int         IMEM_DEPTH_DEF = 32;
    localparam int         NUM_REGS_DEF   = 8;

    function automatic logic [6:0] clamp_len(input logic [5:0] len, input int depth);
        if (int'(len) > depth) return 7'(depth);
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/prog_sequencer_seq_down_counter.sv
// Loadable down-counter that saturates at zero; shared by word and run-cycle counting.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (!rst_n)                  count <= '0;
        else if (load)               count <= load_val;
        else if (en && count != '0)  count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Loads a program into processor instruction memory, runs it for a fixed
// number of cycles, then streams the processor's general registers out.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | accepting source words, then one blank write-port cycle
//   RUN   | working held high for run_cycles
//   DUMP  | stepping rID and handing register values out
//   DONE  | one-cycle completion pulse
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  prog_len,
    input  logic [15:0] run_cycles,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [31:0] src_data,
    output logic [31:0] addr,
    output logic        wr,
    output logic [31:0] wdata,
    output logic        working,
    output logic [3:0]  rID,
    input  logic [31:0] rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [2:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        busy,
    output logic        done
);

    state_t      state, state_nx;
    logic [31:0] addr_nx, wdata_nx, dump_data_nx;
    logic        wr_nx, working_nx, src_ready_nx, dump_valid_nx, busy_nx, done_nx;
    logic [3:0]  rid_nx;
    logic [2:0]  dump_idx_nx;
    logic [6:0]  widx, widx_nx, len_c, wcnt;
    logic        run_nz, run_nz_nx;
    logic        wcnt_load, wcnt_en, wzero;
    logic        rcnt_load, rcnt_en, rzero;
    logic [15:0] rcnt, rcnt_init;

    assign len_c     = clamp_len(prog_len, IMEM_DEPTH);
    // Preloading run_cycles-1 lets the zero flag mark the final working cycle.
    assign rcnt_init = (run_cycles == 16'd0) ? 16'd0 : run_cycles - 16'd1;

    seq_down_counter #(.W(7)) u_word_cnt (
        .clock(clock), .rst_n(rst_n), .load(wcnt_load), .load_val(len_c),
        .en(wcnt_en), .count(wcnt), .zero(wzero)
    );

    seq_down_counter #(.W(16)) u_run_cnt (
        .clock(clock), .rst_n(rst_n), .load(rcnt_load), .load_val(rcnt_init),
        .en(rcnt_en), .count(rcnt), .zero(rzero)
    );

    always_comb begin
        state_nx      = state;
        addr_nx       = addr;
        wr_nx         = 1'b0;
        wdata_nx      = wdata;
        working_nx    = working;
        rid_nx        = rID;
        src_ready_nx  = src_ready;
        dump_valid_nx = dump_valid;
        dump_idx_nx   = dump_idx;
        dump_data_nx  = dump_data;
        widx_nx       = widx;
        run_nz_nx     = run_nz;
        wcnt_load     = 1'b0;
        wcnt_en       = 1'b0;
        rcnt_load     = 1'b0;
        rcnt_en       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    wcnt_load = 1'b1;
                    rcnt_load = 1'b1;
                    run_nz_nx = (run_cycles != 16'd0);
                    widx_nx   = 7'd0;
                    if (len_c == 7'd0) begin
                        state_nx   = RUN;
                        working_nx = (run_cycles != 16'd0);
                    end else begin
                        state_nx     = LOAD;
                        src_ready_nx = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (src_ready && src_valid) begin
                    wr_nx    = 1'b1;
                    addr_nx  = 32'(widx);
                    wdata_nx = src_data;
                    widx_nx  = widx + 7'd1;
                    wcnt_en  = 1'b1;
                    if (wcnt == 7'd1) src_ready_nx = 1'b0;
                end else if (wzero) begin
                    // Last word written: blank the port for a cycle, then run.
                    if (wr) begin
                        addr_nx  = 32'd0;
                        wdata_nx = 32'd0;
                    end else begin
                        state_nx   = RUN;
                        working_nx = run_nz;
                    end
                end
            end
            RUN: begin
                rcnt_en = (rcnt != 16'd0);
                if (rzero) begin
                    working_nx    = 1'b0;
                    state_nx      = DUMP;
                    rid_nx        = 4'd0;
                    dump_valid_nx = 1'b0;
                end
            end
            DUMP: begin
                if (!dump_valid) begin
                    dump_data_nx  = rdata;
                    dump_idx_nx   = rID[2:0];
                    dump_valid_nx = 1'b1;
                end else if (dump_ready) begin
                    dump_valid_nx = 1'b0;
                    if (dump_idx == 3'(NUM_REGS - 1)) begin
                        rid_nx   = IDLE_RID;
                        state_nx = DONE;
                    end else begin
                        rid_nx = rID + 4'd1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= 32'd0;
            wr         <= 1'b0;
            wdata      <= 32'd0;
            working    <= 1'b0;
            rID        <= IDLE_RID;
            src_ready  <= 1'b0;
            dump_valid <= 1'b0;
            dump_idx   <= 3'd0;
            dump_data  <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            widx       <= 7'd0;
            run_nz     <= 1'b0;
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            wr         <= wr_nx;
            wdata      <= wdata_nx;
            working    <= working_nx;
            rID        <= rid_nx;
            src_ready  <= src_ready_nx;
            dump_valid <= dump_valid_nx;
            dump_idx   <= dump_idx_nx;
            dump_data  <= dump_data_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            widx       <= widx_nx;
            run_nz     <= run_nz_nx;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table of whole load/run/dump
// transactions plus hand-written reset and idle sequences.
module tb_prog_sequencer;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  prog_len = 6'd0;
    logic [15:0] run_cycles = 16'd0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [31:0] src_data = 32'd0;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  rID;
    logic [31:0] rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [2:0]  dump_idx;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    prog_sequencer dut (
        .clock(clock), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .addr(addr), .wr(wr), .wdata(wdata),
        .working(working), .rID(rID), .rdata(rdata), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Processor readback model: register n holds n+100.
    assign rdata = 32'(rID) + 32'd100;

    typedef struct {
        logic [5:0]  len;
        logic [15:0] run;
        int          gap_after;
        int          gap_len;
        int          stall_idx;
        int          stall_len;
        bit          restart;
        int          exp_writes;
        int          exp_span;
        int          exp_work;
        int          dump_by;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return 32'h10F00001;
            1:       return 32'h10F10002;
            2:       return 32'h7000000A;
            default: return 32'hA5000000 | 32'(i);
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        int  nwr = 0, src_idx = 0, gap_left = 0, stall_left = v.stall_len;
        int  wcnt = 0, first_w = -1, last_w = -1, first_wr = -1, last_wr = -1;
        int  dump_k = -1, xfer = 0, exp_addr = 0;
        bit  nxt_wr = 1'b0, finished = 1'b0;

        @(negedge clock);
        start = 1'b1; prog_len = v.len; run_cycles = v.run;
        src_valid = 1'b0; dump_ready = 1'b1;
        for (int k = 1; k < 600 && !finished; k++) begin
            @(negedge clock);
            start = 1'b0;
            chk("wr", 32'(wr), 32'(nxt_wr));
            if (wr && nxt_wr) begin
                chk("addr", addr, 32'(exp_addr));
                chk("wdata", wdata, word_of(exp_addr));
                nwr++;
                if (first_wr < 0) first_wr = k;
                last_wr = k;
            end
            if (!wr && nwr > 0 && nwr == v.exp_writes && k == last_wr + 1) begin
                chk("idle_addr", addr, 32'd0);
                chk("idle_wdata", wdata, 32'd0);
            end
            if (working) begin
                wcnt++;
                if (first_w < 0) first_w = k;
                last_w = k;
                if (wcnt == 1) chk("busy_run", 32'(busy), 32'd1);
                if (wcnt == 2 && v.restart) begin
                    start = 1'b1; prog_len = 6'd7; run_cycles = 16'd9;
                end
            end
            if (rID == 4'd0 && dump_k < 0) dump_k = k;
            dump_ready = 1'b1;
            if (dump_valid) begin
                if (xfer == v.stall_idx && stall_left > 0) begin
                    dump_ready = 1'b0;
                    stall_left--;
                    chk("stall_rid", 32'(rID), 32'(xfer));
                    chk("stall_data", dump_data, 32'(xfer + 100));
                end else begin
                    chk("dump_idx", 32'(dump_idx), 32'(xfer));
                    chk("dump_data", dump_data, 32'(xfer + 100));
                    xfer++;
                end
            end
            if (done) begin
                chk("done_xfers", 32'(xfer), 32'd8);
                chk("done_rid", 32'(rID), 32'hF);
                src_valid = 1'b0;
                @(negedge clock);
                chk("done_pulse", 32'(done), 32'd0);
                chk("busy_after", 32'(busy), 32'd0);
                finished = 1'b1;
            end else begin
                nxt_wr = 1'b0;
                if (gap_left > 0) begin
                    src_valid = 1'b0;
                    gap_left--;
                end else begin
                    src_valid = 1'b1;
                end
                src_data = word_of(src_idx);
                if (src_valid && src_ready) begin
                    nxt_wr = 1'b1;
                    exp_addr = src_idx;
                    src_idx++;
                    if (src_idx == v.gap_after) gap_left = v.gap_len;
                end
            end
        end
        src_valid = 1'b0;
        if (!finished) chk("timeout", 32'd0, 32'd1);
        chk("writes", 32'(nwr), 32'(v.exp_writes));
        if (v.exp_writes > 0) chk("write_span", 32'(last_wr - first_wr + 1), 32'(v.exp_span));
        chk("work_cycles", 32'(wcnt), 32'(v.exp_work));
        if (v.exp_work > 0) chk("work_span", 32'(last_w - first_w + 1), 32'(v.exp_work));
        if (v.exp_work > 0 && v.exp_writes > 0) chk("idle_gap", 32'(first_w - last_wr), 32'd2);
        if (v.dump_by > 0) chk("dump_entry", 32'(dump_k > 0 && dump_k <= v.dump_by), 32'd1);
        chk("xfers", 32'(xfer), 32'd8);
    endtask

    initial begin
        int wcnt;
        int nwr;
        //          len    run    gapA gapL stI stL rst wr span work dumpby
        vecs[0] = '{6'd3,  16'd5, 0,   0,   0,  0,  0,  3,  3,  5,   0};
        vecs[1] = '{6'd3,  16'd5, 1,   4,   2,  3,  0,  3,  7,  5,   0};
        vecs[2] = '{6'd0,  16'd0, 0,   0,   0,  0,  0,  0,  0,  0,   2};
        vecs[3] = '{6'd40, 16'd2, 0,   0,   0,  0,  0,  32, 32, 2,   0};
        vecs[4] = '{6'd3,  16'd5, 0,   0,   0,  0,  1,  3,  3,  5,   0};
        vecs[5] = '{6'd1,  16'd1, 0,   0,   7,  2,  0,  1,  1,  1,   0};

        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_working", 32'(working), 32'd0);
        chk("rst_rid", 32'(rID), 32'hF);
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_idx", 32'(dump_idx), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clock);
        end

        // Reset asserted on the third working cycle of a run.
        start = 1'b1; prog_len = 6'd2; run_cycles = 16'd10;
        src_valid = 1'b1; dump_ready = 1'b1;
        wcnt = 0;
        for (int k = 0; k < 100 && wcnt < 3; k++) begin
            @(negedge clock);
            start = 1'b0;
            src_data = word_of(k);
            if (working) wcnt++;
        end
        chk("mid_run_reached", 32'(wcnt), 32'd3);
        rst_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_working", 32'(working), 32'd0);
        chk("mid_rst_rid", 32'(rID), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        nwr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (wr || src_ready) nwr++;
        end
        chk("post_rst_writes", 32'(nwr), 32'd0);
        src_valid = 1'b0;

        // One more normal run after the reset to confirm clean recovery.
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter IMEM_DEPTH, default 32, is the number of instruction-memory words the sequencer can load.
REQ-002 Parameter NUM_REGS, default 8, is the number of general registers dumped after a run.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin load/run/dump; honoured only in IDLE.
REQ-006 prog_len  in  6  words to load; latched on accepted start.
REQ-007 run_cycles  in  16  cycles to hold working high; latched on accepted start.
REQ-008 src_valid / src_ready  in / out  1 / 1  instruction-word source handshake.
REQ-009 src_data  in  32  instruction word, valid when src_valid is high.
REQ-010 addr / wr / wdata  out  32 / 1 / 32  processor instruction-memory write port.
REQ-011 working  out  1  processor run enable.
REQ-012 rID  out  4  processor register-readback select; idle value 4'hF.
REQ-013 rdata  in  32  processor readback; valid one cycle after rID changes.
REQ-014 dump_valid / dump_ready  out / in  1 / 1  register-dump handshake.
REQ-015 dump_idx / dump_data  out  3 / 32  register index and value, stable while dump_valid is high.
REQ-016 busy / done  out  1 / 1  busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-017 The state machine SHALL have exactly five states: IDLE, LOAD, RUN, DUMP, DONE.
REQ-018 IDLE -> LOAD on start; the latched length SHALL be clamped to IMEM_DEPTH; a length of 0 SHALL go directly to RUN.
REQ-019 LOAD: src_ready SHALL be high; each src_valid&src_ready handshake SHALL produce, on the next cycle, wr=1, addr=word index (starting at 0), and wdata=src_data for exactly one cycle.
REQ-020 LOAD: while src_valid is low, wr SHALL be 0 and the word index SHALL hold.
REQ-021 After the final word's write cycle, the block SHALL drive one cycle of wr=0, addr=0, wdata=0, then enter RUN.
REQ-022 RUN: working SHALL be high for exactly run_cycles consecutive cycles, then low; run_cycles=0 SHALL skip directly to DUMP with working never asserted.
REQ-023 DUMP: rID SHALL step 0..NUM_REGS-1; rdata SHALL be captured one cycle after each rID value is presented and held in dump_data with dump_valid=1.
REQ-024 DUMP: rID and dump_data SHALL hold while dump_valid&!dump_ready; a transfer SHALL occur on a cycle where dump_valid&dump_ready are both high.
REQ-025 After the transfer of index NUM_REGS-1: rID SHALL return to 4'hF, the state SHALL become DONE, done SHALL be high for one cycle, then the state SHALL return to IDLE.
REQ-026 start outside IDLE SHALL be ignored; src_ready SHALL be 0 outside LOAD; dump_valid SHALL be 0 outside DUMP.
REQ-027 Every output listed in REQ-010 to REQ-016 SHALL be driven from a register.

Reset
REQ-028 On a clock edge with rst_n=0, the block SHALL set state=IDLE, addr=0, wr=0, wdata=0, working=0, rID=4'hF, src_ready=0, dump_valid=0, dump_idx=0, dump_data=0, busy=0, done=0, and clear all counters.
REQ-029 Reset SHALL take priority in any state; a mid-RUN reset SHALL drop working on that edge and SHALL NOT cause any further memory write.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the IDLE_RID constant (4'hF), and the IMEM_DEPTH and NUM_REGS defaults.
REQ-031 A single sub-module, seq_down_counter (loadable, enabled, with a zero flag), SHALL be used for both the run-cycle countdown and the load-word count.

Verification
REQ-032 prog_len=3, run_cycles=5, source always valid with words 32'h10F00001, 32'h10F10002, 32'h7000000A -> writes at addr 0,1,2 on consecutive cycles, then one idle cycle, then working high for exactly 5 cycles.
REQ-033 Source deasserts src_valid for 4 cycles after word 1 -> no write occurs during the gap, and addr 1 receives word 2 once src_valid returns.
REQ-034 Processor model returns rdata=rID+100 and dump_ready is held low for 3 cycles on index 2 -> dump transfers 100..107 in index order, with index 2's data stable through the stall; a done pulse follows.
REQ-035 prog_len=0, run_cycles=0 -> no write, working never asserted, DUMP entered within 2 cycles of start.
REQ-036 prog_len=40 -> exactly 32 writes at addr 0..31.
REQ-037 start re-pulsed during RUN -> ignored; run length unchanged.
REQ-038 rst_n low at RUN cycle 3 -> working=0, rID=4'hF, and busy=0 on that edge.
